// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise LSU has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                err_o
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_t;

    state_t           state;
    logic             owner;  // 1 = LSU
    logic [CNT_W-1:0] cnt;

    logic any_req;
    logic winner;
    logic sel_lsu;
    logic fwd;
    logic grant;
    logic timeout;
    logic done;

    assign any_req = if_req_i | lsu_req_i;

`ifdef MEM_ARB_RR_EN
    logic last_lsu;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_lsu <= 1'b0;
        end else if (grant) begin
            last_lsu <= sel_lsu;
        end
    end

    // On a tie the port goes to whoever was not granted last
    assign winner = lsu_req_i & (~if_req_i | ~last_lsu);
`else
    assign winner = lsu_req_i;
`endif

    assign sel_lsu = (state == StIdle) ? winner : owner;
    assign fwd     = ~rst_i & (((state == StIdle) & any_req) | (state == StReq));
    assign grant   = fwd & mem_gnt_i;
    assign timeout = (TIMEOUT != 0) && (state == StResp) && (cnt == TO_LIMIT) && !mem_rvalid_i;
    assign done    = ~rst_i & (state == StResp) & (mem_rvalid_i | timeout);

    always_comb begin
        mem_req_o   = fwd;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (fwd) begin
            if (sel_lsu) begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = if_addr_i;
            end
        end
    end

    assign if_gnt_o     = grant & ~sel_lsu;
    assign lsu_gnt_o    = grant & sel_lsu;
    assign if_rvalid_o  = done & ~owner;
    assign lsu_rvalid_o = done & owner;
    assign if_rdata_o   = (rst_i | timeout) ? '0 : mem_rdata_i;
    assign lsu_rdata_o  = (rst_i | timeout) ? '0 : mem_rdata_i;
    assign err_o        = ~rst_i & timeout;
    assign busy_o       = (state != StIdle);

    // cnt is loaded with 1 on grant so it equals the number of cycles spent in StResp
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= StIdle;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (any_req) begin
                        owner <= winner;
                        if (mem_gnt_i) begin
                            state <= StResp;
                            cnt   <= CNT_W'(1);
                        end else begin
                            state <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt_i) begin
                        state <= StResp;
                        cnt   <= CNT_W'(1);
                    end
                end
                StResp: begin
                    if (done) begin
                        state <= StIdle;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
